// File: rtl/cpu_pkg.sv
// Shared constants, ALU opcode enum and pipeline-register payloads for the rv32i_cpu core.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0]      OP_IMM   = 7'b0010011;
    localparam logic [6:0]      OP_LUI   = 7'b0110111;
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SLL  = 3'b001,
        ALU_SLT  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SR   = 3'b101,
        ALU_OR   = 3'b110,
        ALU_AND  = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0] insn;
    } if_id_t;

    typedef struct packed {
        logic [XLEN-1:0] insn;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] op_b;
        logic            wb_en;
    } id_ex_t;

    typedef struct packed {
        logic [XLEN-1:0] insn;
        logic [XLEN-1:0] result;
        logic            wb_en;
    } ex_mem_t;

    typedef struct packed {
        logic [XLEN-1:0] insn;
        logic [XLEN-1:0] result;
        logic            wb_en;
    } mem_wb_t;

    localparam if_id_t  IF_ID_NOP  = '{insn: NOP_INSN};
    localparam id_ex_t  ID_EX_NOP  = '{insn: NOP_INSN, rs1_val: '0, op_b: '0, wb_en: 1'b0};
    localparam ex_mem_t EX_MEM_NOP = '{insn: NOP_INSN, result: '0, wb_en: 1'b0};
    localparam mem_wb_t MEM_WB_NOP = '{insn: NOP_INSN, result: '0, wb_en: 1'b0};

    function automatic logic [4:0] rd_of(input logic [XLEN-1:0] insn);
        return insn[11:7];
    endfunction

    function automatic logic [4:0] rs1_of(input logic [XLEN-1:0] insn);
        return insn[19:15];
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 32x32 register file: two combinational read ports, one write port, x0 hardwired to zero,
// reads of the register being written return the new value.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_c_o,
    output logic [XLEN-1:0] rs2_data_c_o,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i
);

    localparam int unsigned NREG = 32;

    logic [XLEN-1:0] regs_q [NREG];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rs1_data_c_o = (rs1_addr_i == 5'd0)             ? '0   :
                          (we_i && (wa_i == rs1_addr_i))   ? wd_i : regs_q[rs1_addr_i];
    assign rs2_data_c_o = (rs2_addr_i == 5'd0)             ? '0   :
                          (we_i && (wa_i == rs2_addr_i))   ? wd_i : regs_q[rs2_addr_i];

endmodule

// File: rtl/rv32i_cpu.sv
// 5-stage in-order RV32I core (OP-IMM and LUI) with per-retirement trace ports.
// Define CPU_FWD_EN for EX operand forwarding; without it ID interlocks on RAW hazards.
module rv32i_cpu
    import cpu_pkg::*;
#(
    parameter int unsigned     word_size    = XLEN,
    parameter int unsigned     address_size = XLEN,
    parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [address_size-1:0] imem_addr,
    input  logic [word_size-1:0]    imem_insn,
    output logic [address_size-1:0] dmem_addr,
    inout  wire  [word_size-1:0]    dmem_data,
    output logic                    dmem_wen,
    output logic [word_size-1:0]    trace_instruction,
    output logic [4:0]              trace_rd,
    output logic [4:0]              trace_rs1,
    output logic [4:0]              trace_rs2,
    output logic [11:0]             trace_imm,
    output logic [word_size-1:0]    trace_rd_value
);

    logic [address_size-1:0] pc_q, pc_d;
    if_id_t  if_id_q,  if_id_d;
    id_ex_t  id_ex_q,  id_ex_d;
    ex_mem_t ex_mem_q, ex_mem_d;
    mem_wb_t mem_wb_q, mem_wb_d;

    logic            stall;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [XLEN-1:0] ex_a, alu_res;
    logic [6:0]      id_opcode;

    assign id_opcode = if_id_q.insn[6:0];

    cpu_regfile u_regfile (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs1_addr_i   (rs1_of(if_id_q.insn)),
        .rs2_addr_i   (if_id_q.insn[24:20]),
        .rs1_data_c_o (rs1_val),
        .rs2_data_c_o (rs2_val),
        .we_i         (mem_wb_q.wb_en),
        .wa_i         (rd_of(mem_wb_q.insn)),
        .wd_i         (mem_wb_q.result)
    );

`ifdef CPU_FWD_EN
    assign stall = 1'b0;
`else
    // Hold fetch while a producer of the ID rs1 is still in EX or MEM; WB is covered by the regfile bypass.
    assign stall = (rs1_of(if_id_q.insn) != 5'd0) &&
                   ((id_ex_q.wb_en  && (rd_of(id_ex_q.insn)  == rs1_of(if_id_q.insn))) ||
                    (ex_mem_q.wb_en && (rd_of(ex_mem_q.insn) == rs1_of(if_id_q.insn))));
`endif

    // IF: sequential fetch, frozen during an interlock
    always_comb begin
        pc_d    = pc_q + address_size'(4);
        if_id_d = '{insn: XLEN'(imem_insn)};
        if (stall) begin
            pc_d    = pc_q;
            if_id_d = if_id_q;
        end
    end

    // ID: decode, immediate generation and operand read
    always_comb begin
        id_ex_d = ID_EX_NOP;
        if (!stall) begin
            id_ex_d.insn    = if_id_q.insn;
            id_ex_d.rs1_val = rs1_val;
            id_ex_d.wb_en   = ((id_opcode == OP_IMM) || (id_opcode == OP_LUI)) &&
                              (rd_of(if_id_q.insn) != 5'd0);
            if (id_opcode == OP_LUI) begin
                id_ex_d.op_b = {if_id_q.insn[31:12], 12'h000};
            end else if (id_opcode == OP_IMM) begin
                id_ex_d.op_b = {{20{if_id_q.insn[31]}}, if_id_q.insn[31:20]};
            end else begin
                id_ex_d.op_b = rs2_val;
            end
        end
    end

    // EX operand A, newest producer wins
    always_comb begin
        ex_a = id_ex_q.rs1_val;
`ifdef CPU_FWD_EN
        if (ex_mem_q.wb_en && (rd_of(ex_mem_q.insn) == rs1_of(id_ex_q.insn))) begin
            ex_a = ex_mem_q.result;
        end else if (mem_wb_q.wb_en && (rd_of(mem_wb_q.insn) == rs1_of(id_ex_q.insn))) begin
            ex_a = mem_wb_q.result;
        end
`endif
    end

    always_comb begin
        alu_res = '0;
        if (id_ex_q.insn[6:0] == OP_LUI) begin
            alu_res = id_ex_q.op_b;
        end else begin
            case (alu_op_e'(id_ex_q.insn[14:12]))
                ALU_ADD:  alu_res = ex_a + id_ex_q.op_b;
                ALU_SLL:  alu_res = ex_a << id_ex_q.op_b[4:0];
                ALU_SLT:  alu_res = XLEN'($signed(ex_a) < $signed(id_ex_q.op_b));
                ALU_SLTU: alu_res = XLEN'(ex_a < id_ex_q.op_b);
                ALU_XOR:  alu_res = ex_a ^ id_ex_q.op_b;
                ALU_SR:   alu_res = id_ex_q.insn[30] ? XLEN'($signed(ex_a) >>> id_ex_q.op_b[4:0])
                                                     : (ex_a >> id_ex_q.op_b[4:0]);
                ALU_OR:   alu_res = ex_a | id_ex_q.op_b;
                ALU_AND:  alu_res = ex_a & id_ex_q.op_b;
                default:  alu_res = '0;
            endcase
        end
    end

    // Non-writing instructions retire with a zero result
    always_comb begin
        ex_mem_d = '{insn: id_ex_q.insn, result: id_ex_q.wb_en ? alu_res : '0, wb_en: id_ex_q.wb_en};
        mem_wb_d = '{insn: ex_mem_q.insn, result: ex_mem_q.result, wb_en: ex_mem_q.wb_en};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q     <= address_size'(RESET_PC);
            if_id_q  <= IF_ID_NOP;
            id_ex_q  <= ID_EX_NOP;
            ex_mem_q <= EX_MEM_NOP;
            mem_wb_q <= MEM_WB_NOP;
        end else begin
            pc_q     <= pc_d;
            if_id_q  <= if_id_d;
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign imem_addr         = pc_q;
    assign dmem_addr         = '0;
    assign dmem_wen          = 1'b0;
    assign dmem_data         = 'z;
    assign trace_instruction = word_size'(mem_wb_q.insn);
    assign trace_rd          = rd_of(mem_wb_q.insn);
    assign trace_rs1         = rs1_of(mem_wb_q.insn);
    assign trace_rs2         = mem_wb_q.insn[24:20];
    assign trace_imm         = mem_wb_q.insn[31:20];
    assign trace_rd_value    = word_size'(mem_wb_q.result);

endmodule

// File: tb/tb_rv32i_cpu.sv
// Scoreboard bench for rv32i_cpu: programs are loaded into a combinational ROM, expected
// retirements are queued, and a monitor compares every non-NOP retirement in order.
module tb_rv32i_cpu;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] insn;
        logic [4:0]  rd;
        logic [31:0] value;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_insn;
    logic [31:0] dmem_addr;
    wire  [31:0] dmem_data;
    logic        dmem_wen;
    logic [31:0] trace_instruction;
    logic [4:0]  trace_rd;
    logic [4:0]  trace_rs1;
    logic [4:0]  trace_rs2;
    logic [11:0] trace_imm;
    logic [31:0] trace_rd_value;

    logic [31:0] rom [256];
    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;

    rv32i_cpu dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imem_addr         (imem_addr),
        .imem_insn         (imem_insn),
        .dmem_addr         (dmem_addr),
        .dmem_data         (dmem_data),
        .dmem_wen          (dmem_wen),
        .trace_instruction (trace_instruction),
        .trace_rd          (trace_rd),
        .trace_rs1         (trace_rs1),
        .trace_rs2         (trace_rs2),
        .trace_imm         (trace_imm),
        .trace_rd_value    (trace_rd_value)
    );

    always #5 clk = ~clk;

    assign imem_insn = (imem_addr < 32'd1024) ? rom[imem_addr[9:2]] : NOP;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every retirement other than the canonical NOP must match the queue head
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && trace_instruction !== NOP) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL retire_unexpected: got insn 0x%08h, required no retirement", trace_instruction);
            end else begin
                e = exp_q.pop_front();
                check("retire_insn", trace_instruction, e.insn);
                check("retire_rd", 32'(trace_rd), 32'(e.rd));
                check("retire_value", trace_rd_value, e.value);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        foreach (rom[i]) rom[i] = NOP;
    endtask

    task automatic put(input int idx, input logic [31:0] insn, input logic [4:0] rd,
                       input logic [31:0] value);
        exp_t e;
        rom[idx] = insn;
        e.insn   = insn;
        e.rd     = rd;
        e.value  = value;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for the queue to empty, then idle to catch stray retirements
    task automatic drain(input string name);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 60) begin
            @(posedge clk);
            c++;
        end
        repeat (8) @(posedge clk);
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clear_rom();

        // Reset state
        do_reset();
        check("reset_imem_addr", imem_addr, 32'h0);
        check("reset_trace_insn", trace_instruction, NOP);
        check("reset_trace_value", trace_rd_value, 32'h0);
        check("dmem_wen_low", 32'(dmem_wen), 32'h0);
        check("dmem_addr_zero", dmem_addr, 32'h0);

        // Single instruction, fetch sequence and 4-cycle retire latency
        put(0, 32'h0050_0093, 5'd1, 32'd5);
        rst_n = 1'b1;
        check("fetch_pc0", imem_addr, 32'h0);
        @(posedge clk); #1;
        check("fetch_pc4", imem_addr, 32'h4);
        @(posedge clk); #1;
        check("fetch_pc8", imem_addr, 32'h8);
        repeat (2) @(posedge clk); #1;
        check("latency_insn", trace_instruction, 32'h0050_0093);
        check("latency_imm", 32'(trace_imm), 32'h005);
        check("latency_rs1", 32'(trace_rs1), 32'h0);
        drain("drain_single");

        // Back-to-back RAW dependences
        do_reset();
        clear_rom();
        put(0, 32'h0050_0093, 5'd1, 32'd5);   // addi x1,x0,5
        put(1, 32'h0030_8113, 5'd2, 32'd8);   // addi x2,x1,3
        put(2, 32'h0010_8193, 5'd3, 32'd6);   // addi x3,x1,1
        rst_n = 1'b1;
        drain("drain_raw");

        // Writes to x0 are discarded
        do_reset();
        clear_rom();
        put(0, 32'h0070_0013, 5'd0, 32'd0);   // addi x0,x0,7
        put(1, 32'h0000_0213, 5'd4, 32'd0);   // addi x4,x0,0
        rst_n = 1'b1;
        drain("drain_x0");

        // Sign extension and shifts
        do_reset();
        clear_rom();
        put(0, 32'hFF00_0093, 5'd1, 32'hFFFF_FFF0);  // addi x1,x0,-16
        put(1, 32'h4020_D113, 5'd2, 32'hFFFF_FFFC);  // srai x2,x1,2
        put(2, 32'h01C0_D193, 5'd3, 32'h0000_000F);  // srli x3,x1,28
        put(3, 32'hFFF0_3213, 5'd4, 32'h0000_0001);  // sltiu x4,x0,-1
        rst_n = 1'b1;
        drain("drain_shift");

        // LUI, logic ops, slti, slli and an unsupported opcode
        do_reset();
        clear_rom();
        put(0, 32'h1234_52B7, 5'd5,  32'h1234_5000);  // lui  x5,0x12345
        put(1, 32'h6782_E313, 5'd6,  32'h1234_5678);  // ori  x6,x5,0x678
        put(2, 32'hFFF3_4393, 5'd7,  32'hEDCB_A987);  // xori x7,x6,-1
        put(3, 32'h0003_A413, 5'd8,  32'h0000_0001);  // slti x8,x7,0
        put(4, 32'h0F03_7493, 5'd9,  32'h0000_0070);  // andi x9,x6,0xF0
        put(5, 32'h0043_1513, 5'd10, 32'h2345_6780);  // slli x10,x6,4
        put(6, 32'h0020_81B3, 5'd3,  32'h0000_0000);  // add x3,x1,x2 (not supported)
        rst_n = 1'b1;
        drain("drain_logic");

        // Reset with three instructions in flight
        do_reset();
        clear_rom();
        rom[0] = 32'h0090_0293;   // addi x5,x0,9
        rom[1] = 32'h00A0_0313;   // addi x6,x0,10
        rom[2] = 32'h00B0_0393;   // addi x7,x0,11
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("midreset_trace", trace_instruction, NOP);
        check("midreset_pc", imem_addr, 32'h0);
        clear_rom();
        put(0, 32'h0012_8413, 5'd8, 32'd1);   // addi x8,x5,1
        put(1, 32'h0003_0493, 5'd9, 32'd0);   // addi x9,x6,0
        rst_n = 1'b1;
        check("restart_pc", imem_addr, 32'h0);
        drain("drain_midreset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
